// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480 raster timing: counters, syncs, blank, line/frame strobes
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic        pix_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        vblank_tick,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE - 1);
    // Decode bounds are 11 bits so a 1024-wide total still compares correctly.
    localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [9:0]       x_d;
    logic [9:0]       y_d;
    logic             h_wrap;
    logic             in_hs;
    logic             in_vs;
    logic             in_vis;

    assign h_wrap = pix_en && (DrawX == H_LAST);

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        x_d   = DrawX;
        y_d   = DrawY;
        if (pix_en) begin
            if (DrawX == H_LAST) begin
                x_d = '0;
                y_d = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
            end else begin
                x_d = DrawX + 10'd1;
            end
        end
    end

    // Syncs and blank are decoded from the next counter values so they line up with DrawX/DrawY.
    always_comb begin
        in_hs  = ({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END);
        in_vs  = ({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END);
        in_vis = ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            div_q       <= '0;
            pix_en      <= 1'b0;
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b1;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            line_start  <= 1'b0;
            vblank_tick <= 1'b0;
            frame_count <= '0;
        end else begin
            div_q       <= div_d;
            pix_en      <= (div_d == DIV_LAST);
            DrawX       <= x_d;
            DrawY       <= y_d;
            blank       <= in_vis;
            hs          <= in_hs ? SYNC_POL : ~SYNC_POL;
            vs          <= in_vs ? SYNC_POL : ~SYNC_POL;
            line_start  <= h_wrap;
            vblank_tick <= h_wrap && (DrawY == V_ACT_END);
            if (vblank_tick) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized check of vga_timing_gen against an absolute-pixel-count model
module tb_vga_timing_gen;
    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic        pe_o [3];
    logic [9:0]  dx_o [3];
    logic [9:0]  dy_o [3];
    logic        bl_o [3];
    logic        hs_o [3];
    logic        vs_o [3];
    logic        ls_o [3];
    logic        vb_o [3];
    logic [15:0] fc_o [3];

    vga_timing_gen u0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pe_o[0]), .DrawX(dx_o[0]), .DrawY(dy_o[0]),
        .blank(bl_o[0]), .hs(hs_o[0]), .vs(vs_o[0]), .line_start(ls_o[0]),
        .vblank_tick(vb_o[0]), .frame_count(fc_o[0])
    );
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(8), .V_FP(2),
                     .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .CLK_DIV(1)) u1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pe_o[1]), .DrawX(dx_o[1]), .DrawY(dy_o[1]),
        .blank(bl_o[1]), .hs(hs_o[1]), .vs(vs_o[1]), .line_start(ls_o[1]),
        .vblank_tick(vb_o[1]), .frame_count(fc_o[1])
    );
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(8), .V_FP(2),
                     .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1), .CLK_DIV(2)) u2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pe_o[2]), .DrawX(dx_o[2]), .DrawY(dy_o[2]),
        .blank(bl_o[2]), .hs(hs_o[2]), .vs(vs_o[2]), .line_start(ls_o[2]),
        .vblank_tick(vb_o[2]), .frame_count(fc_o[2])
    );

    int ha [3], hf [3], hsy [3], hb [3], va [3], vf [3], vsy [3], vbp [3], dv [3];
    bit pol [3];

    // Model state: clocks since reset, pixels advanced, frames ticked.
    int      mc   [3];
    longint  mp   [3];
    int      mfc  [3];
    bit      madv [3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    function automatic int htot(int i);
        return ha[i] + hf[i] + hsy[i] + hb[i];
    endfunction
    function automatic int vtot(int i);
        return va[i] + vf[i] + vsy[i] + vbp[i];
    endfunction
    function automatic int ex(int i);
        return int'(mp[i] % longint'(htot(i)));
    endfunction
    function automatic int ey(int i);
        return int'((mp[i] / longint'(htot(i))) % longint'(vtot(i)));
    endfunction
    function automatic bit e_pe(int i);
        return (mc[i] >= 1) && ((mc[i] % dv[i]) == dv[i] - 1);
    endfunction
    function automatic bit e_vb(int i);
        return madv[i] && ex(i) == 0 && ey(i) == va[i];
    endfunction

    task automatic model_step(input logic r);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                mc[i] = 0; mp[i] = 0; mfc[i] = 0; madv[i] = 0;
            end else begin
                bit pe_prev, vb_prev;
                pe_prev = e_pe(i);
                vb_prev = e_vb(i);
                mc[i]++;
                if (pe_prev) mp[i]++;
                madv[i] = pe_prev;
                if (vb_prev) mfc[i] = (mfc[i] + 1) & 32'hFFFF;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            int x, y;
            bit hsa, vsa;
            x = ex(i);
            y = ey(i);
            hsa = (x >= ha[i] + hf[i]) && (x < ha[i] + hf[i] + hsy[i]);
            vsa = (y >= va[i] + vf[i]) && (y < va[i] + vf[i] + vsy[i]);
            chk($sformatf("u%0d.pix_en", i), int'(pe_o[i]), int'(e_pe(i)));
            chk($sformatf("u%0d.DrawX", i), int'(dx_o[i]), x);
            chk($sformatf("u%0d.DrawY", i), int'(dy_o[i]), y);
            chk($sformatf("u%0d.blank", i), int'(bl_o[i]), int'(x < ha[i] && y < va[i]));
            chk($sformatf("u%0d.hs", i), int'(hs_o[i]), int'(hsa ? pol[i] : !pol[i]));
            chk($sformatf("u%0d.vs", i), int'(vs_o[i]), int'(vsa ? pol[i] : !pol[i]));
            chk($sformatf("u%0d.line_start", i), int'(ls_o[i]), int'(madv[i] && x == 0));
            chk($sformatf("u%0d.vblank_tick", i), int'(vb_o[i]), int'(e_vb(i)));
            chk($sformatf("u%0d.frame_count", i), int'(fc_o[i]), mfc[i]);
        end
    endtask

    task automatic cyc(input logic r);
        reset_n = r;
        @(posedge vga_clk);
        model_step(r);
        @(negedge vga_clk);
        compare_all();
    endtask

    int hs_low0, ls0, vb1, pe2, last_ls, cyc_n;

    initial begin
        for (int i = 0; i < 3; i++) begin
            ha[i] = 16; hf[i] = 2; hsy[i] = 4; hb[i] = 3;
            va[i] = 8;  vf[i] = 2; vsy[i] = 2; vbp[i] = 3;
            pol[i] = 1'b0; dv[i] = 1;
        end
        ha[0] = 640; hf[0] = 16; hsy[0] = 96; hb[0] = 48;
        va[0] = 480; vf[0] = 10; vsy[0] = 2;  vbp[0] = 33;
        pol[2] = 1'b1; dv[2] = 2;

        @(negedge vga_clk);
        for (int k = 0; k < 3; k++) cyc(1'b0);

        // Directed run from reset: one-and-a-bit default lines plus several small frames.
        hs_low0 = 0; ls0 = 0; vb1 = 0; pe2 = 0; last_ls = -1;
        for (int k = 1; k <= 1700; k++) begin
            cyc(1'b1);
            if (hs_o[0] == 1'b0) hs_low0++;
            if (vb_o[1]) vb1++;
            if (pe_o[2]) pe2++;
            if (ls_o[0]) begin
                ls0++;
                if (last_ls >= 0) chk("line_period", k - last_ls, 800);
                last_ls = k;
            end
        end
        chk("hs_low_cycles", hs_low0, 192);
        chk("line_start_count", ls0, 2);
        chk("vblank_count_small", vb1, 4);
        chk("frames_small", int'(fc_o[1]), 4);
        chk("pix_en_div2", pe2, 850);

        // Preload the small instance near wrap and let a few frames roll it over.
        force u1.frame_count = 16'hFFFD;
        #1;
        release u1.frame_count;
        mfc[1] = 32'hFFFD;
        for (int k = 0; k < 1500; k++) cyc(1'b1);
        chk("fc_wrapped", int'(fc_o[1]), 1);

        // Random runs with mid-frame resets.
        for (int s = 0; s < 10; s++) begin
            int rl, nl;
            rl = $urandom_range(1, 2);
            nl = $urandom_range(200, 2500);
            for (int k = 0; k < rl; k++) cyc(1'b0);
            for (int k = 0; k < nl; k++) cyc(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates raster timing for the 640x480 display pipeline. Produces DrawX/DrawY, blank, hs and vs, which feed the sprite/background compositor and the VGA pins. Also provides a pixel enable, line/frame strobes and a frame counter that game logic (character/ball position update, score latch) uses to update state once per frame during vertical blanking.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low hs/vs)
CLK_DIV, 1, vga_clk cycles per pixel (>=1)

Ports:
vga_clk  in  1  pixel-domain clock; all logic on posedge
reset_n  in  1  synchronous reset, active-low
pix_en  out  1  high in cycles where the raster advances
DrawX  out  10  current column, 0..H_TOTAL-1
DrawY  out  10  current line, 0..V_TOTAL-1
blank  out  1  1 = inside the visible area (DrawX<H_ACTIVE && DrawY<V_ACTIVE); 0 = blanking
hs  out  1  horizontal sync at SYNC_POL level while asserted
vs  out  1  vertical sync at SYNC_POL level while asserted
line_start  out  1  one-cycle strobe on each horizontal wrap
vblank_tick  out  1  one-cycle strobe at the start of vertical blanking
frame_count  out  16  frames completed, wraps

Behaviour:
- Clocking and reset: one clock (vga_clk). Reset is synchronous, active-low (reset_n).
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be <=1024.
- Reset (reset_n=0 at posedge): divider=0, DrawX=0, DrawY=0, blank=1, hs=vs=~SYNC_POL, pix_en=0, line_start=0, vblank_tick=0, frame_count=0. Reset mid-frame takes effect the next cycle, with no partial strobe.
- Divider: counts 0..CLK_DIV-1. pix_en=1 in the cycle where divider==CLK_DIV-1 and reset_n=1. With CLK_DIV=1, pix_en=1 in every cycle out of reset.
- Counters: on a pix_en cycle, DrawX increments. At DrawX==H_TOTAL-1, DrawX goes to 0 and DrawY increments. At DrawY==V_TOTAL-1 with the horizontal wrap, DrawY goes to 0. Counters hold when pix_en=0.
- All outputs are registers. hs, vs and blank are decoded from the next counter values, so they always describe the same pixel as DrawX/DrawY in the same cycle. Latency from counter to sync/blank is 0 pixels.
- hs asserted iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs asserted iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491).
- line_start: high for exactly one vga_clk cycle, the first cycle in which DrawX==0 after a horizontal wrap. It does not fire for the post-reset (0,0).
- vblank_tick: high for exactly one vga_clk cycle, the first cycle with DrawY==V_ACTIVE and DrawX==0. frame_count increments in that same cycle (new value visible the next cycle).
- frame_count wraps 0xFFFF -> 0x0000 with no flag.
- Full-frame wrap at (H_TOTAL-1, V_TOTAL-1): the next state is (0,0) with blank=1 and line_start=1. vblank_tick does not fire on this wrap.
- Each strobe is at most one cycle wide regardless of CLK_DIV.

Test Plan:
1. CLK_DIV=1; release reset, run one line -> line period 800 cycles; hs low exactly for DrawX 656..751 (96 cycles); line_start once at cycle 800.
2. Run one full frame -> 420000 cycles between DrawY==0 wraps; vs low for DrawY 490..491 (1600 cycles); blank=1 for exactly 307200 cycles.
3. Run 3 frames -> vblank_tick fires 3 times, each at (0,480); frame_count reads 3; no vblank_tick at (0,0).
4. Preload via 65535 simulated frames (or a force) -> frame_count 0xFFFF -> 0x0000 at the next vblank_tick.
5. Assert reset_n=0 for one cycle at (300,200) -> next cycle DrawX=0, DrawY=0, hs=vs=1, blank=1, frame_count=0, no strobes.
6. CLK_DIV=2 -> pix_en alternates 0/1; line = 1600 vga_clk cycles; hs low 192 cycles; line_start stays one cycle wide.
